// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam int unsigned RamAwDefault = 17;

  typedef enum logic [2:0] {
    McIdle,
    McIfRd,
    McMemRd,
    McMemWr,
    McDone
  } mc_state_e;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  // 2'b11 is treated as a word access.
  function automatic logic [2:0] byte_count(logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      LenWord: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM requests onto a byte-wide synchronous RAM, assembling
// little-endian reads and splitting stores into byte writes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW = RamAwDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [1:0]        rd_idx;
  logic [1:0]        wr_idx;
  logic [31:0]       assembled;

  // Upper address bits lie outside the RAM and are ignored.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

  // cnt_q counts edges since the request was sampled; the byte on ram_rdata
  // now was addressed two edges ago.
  assign rd_idx = 2'(cnt_q - 3'd2);
  assign wr_idx = cnt_q[1:0];

  always_comb begin
    assembled = buf_q;
    assembled[{rd_idx, 3'b000} +: 8] = ram_rdata;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      McIdle: begin
        if (mem_req) begin
          state_d    = mem_we ? McMemWr : McMemRd;
          n_d        = byte_count(mem_len);
          wdata_d    = mem_wdata;
          buf_d      = '0;
          ram_addr_d = mem_addr[RAM_AW-1:0];
          cnt_d      = 3'd1;
          if (mem_we) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = mem_wdata[7:0];
          end
        end else if (if_req && !if_flush) begin
          state_d    = McIfRd;
          n_d        = 3'd4;
          buf_d      = '0;
          ram_addr_d = if_addr[RAM_AW-1:0];
          cnt_d      = 3'd1;
        end
      end
      McIfRd, McMemRd: begin
        if (state_q == McIfRd && if_flush) begin
          state_d = McIdle;
          cnt_d   = '0;
        end else begin
          if (cnt_q >= 3'd2) buf_d = assembled;
          if (cnt_q < n_q) ram_addr_d = ram_addr_q + RAM_AW'(1);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n_q + 3'd1) begin
            state_d = McDone;
            cnt_d   = '0;
            if (state_q == McIfRd) begin
              if_data_d = assembled;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = assembled;
              mem_done_d  = 1'b1;
            end
          end
        end
      end
      McMemWr: begin
        if (cnt_q < n_q) begin
          ram_addr_d  = ram_addr_q + RAM_AW'(1);
          ram_we_d    = 1'b1;
          ram_wdata_d = wdata_q[{wr_idx, 3'b000} +: 8];
          cnt_d       = cnt_q + 3'd1;
        end else begin
          state_d    = McDone;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end
      McDone:  state_d = McIdle;
      default: state_d = McIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= McIdle;
      cnt_q       <= '0;
      n_q         <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;

endmodule
